// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard sequencer: stall/flush control for PC, IF/ID and ID/EX.
// Optional perf counters built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int FLUSH_CYCLES     = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             pc_redirect,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        LU_BUBBLE = 2'd2,
        REDIRECT  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       lu, rd, rd_acc;

    assign lu = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                ((id_uses_rs1 && id_rs1 == ex_rd) ||
                 (id_uses_rs2 && id_rs2 == ex_rd));
    assign rd      = ex_valid && ex_redirect;
    assign rd_acc  = !reset && !dmem_busy && rd;
    assign state_o = state;

    // State and countdown register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: busy > redirect > countdown states > load-use
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (dmem_busy) begin
            state_nxt = MEM_WAIT;
        end else if (rd) begin
            if (FLUSH_CYCLES > 1) begin
                state_nxt = REDIRECT;
                cnt_nxt   = 3'(FLUSH_CYCLES - 1);
            end else begin
                state_nxt = RUN;
            end
        end else if (state == REDIRECT || state == LU_BUBBLE) begin
            cnt_nxt = cnt - 3'd1;
            if (cnt <= 3'd1)
                state_nxt = RUN;
        end else if (lu && LOAD_USE_BUBBLES > 1) begin
            state_nxt = LU_BUBBLE;
            cnt_nxt   = 3'(LOAD_USE_BUBBLES - 1);
        end else begin
            state_nxt = RUN;
        end
    end

    // Mealy control outputs; flush always wins over stall on a register
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        pc_redirect = 1'b0;
        if (reset) begin
            pc_stall = 1'b0;
        end else if (dmem_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
        end else if (rd) begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (state == REDIRECT) begin
            if_id_flush = 1'b1;
        end else if (state == LU_BUBBLE || lu) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (rd_acc && flush_events != '1)
                flush_events <= flush_events + CNT_W'(1);
        end
    end
`else
    logic unused_rd_acc;
    assign unused_rd_acc = rd_acc;
    assign stall_cycles  = '0;
    assign flush_events  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Two instances: bubbles=3/flush=2 (a) and defaults 1/1 (b).
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic ex_valid, ex_mem_read, ex_redirect, dmem_busy;

    logic a_pcs, a_ifs, a_iff, a_ies, a_ief, a_red;
    logic b_pcs, b_ifs, b_iff, b_ies, b_ief, b_red;
    logic [1:0] a_st, b_st;
    logic [31:0] a_sc, a_fe, b_sc, b_fe;
    logic [5:0] a_ctl, b_ctl;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign a_ctl = {a_pcs, a_ifs, a_iff, a_ies, a_ief, a_red};
    assign b_ctl = {b_pcs, b_ifs, b_iff, b_ies, b_ief, b_red};

    pipeline_hazard_ctrl #(
        .LOAD_USE_BUBBLES(3), .FLUSH_CYCLES(2), .CNT_W(32)
    ) u_a (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .pc_stall(a_pcs), .if_id_stall(a_ifs), .if_id_flush(a_iff),
        .id_ex_stall(a_ies), .id_ex_flush(a_ief), .pc_redirect(a_red),
        .state_o(a_st), .stall_cycles(a_sc), .flush_events(a_fe)
    );

    pipeline_hazard_ctrl #(
        .LOAD_USE_BUBBLES(1), .FLUSH_CYCLES(1), .CNT_W(32)
    ) u_b (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .pc_stall(b_pcs), .if_id_stall(b_ifs), .if_id_flush(b_iff),
        .id_ex_stall(b_ies), .id_ex_flush(b_ief), .pc_redirect(b_red),
        .state_o(b_st), .stall_cycles(b_sc), .flush_events(b_fe)
    );

    // ctl bit order: pc_stall, if_id_stall, if_id_flush,
    // id_ex_stall, id_ex_flush, pc_redirect
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110010;
    localparam logic [5:0] C_RD   = 6'b001011;
    localparam logic [5:0] C_IFF  = 6'b001000;
    localparam logic [5:0] C_BUSY = 6'b110100;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pc(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic clr();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_valid = 0; ex_mem_read = 0; ex_redirect = 0; dmem_busy = 0;
    endtask

    task automatic set_lu();
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd5;
        id_valid = 1; id_uses_rs2 = 1; id_rs2 = 5'd5;
    endtask

    // advance one clock, then settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1;
        set_lu();
        #2;
        chk("rst_ctl_a", 32'(a_ctl), 32'(C_NONE));
        chk("rst_ctl_b", 32'(b_ctl), 32'(C_NONE));
        chk("rst_st_a", 32'(a_st), 32'd0);
        chk("rst_sc_a", a_sc, 32'd0);
        chk("rst_fe_a", a_fe, 32'd0);
        tick();
        clr();
        reset = 0;
        tick();

        // load-use
        set_lu();
        #1;
        chk("lu0_ctl_a", 32'(a_ctl), 32'(C_LU));
        chk("lu0_ctl_b", 32'(b_ctl), 32'(C_LU));
        chk("lu0_st_a", 32'(a_st), 32'd0);
        tick();
        clr();
        #1;
        chk("lu1_ctl_b", 32'(b_ctl), 32'(C_NONE));
        chk("lu1_st_b", 32'(b_st), 32'd0);
        chk("lu1_ctl_a", 32'(a_ctl), 32'(C_LU));
        chk("lu1_st_a", 32'(a_st), 32'd2);
        tick();
        chk("lu2_ctl_a", 32'(a_ctl), 32'(C_LU));
        chk("lu2_st_a", 32'(a_st), 32'd2);
        tick();
        chk("lu3_ctl_a", 32'(a_ctl), 32'(C_NONE));
        chk("lu3_st_a", 32'(a_st), 32'd0);
        chk("lu_sc_a", a_sc, pc(3));
        chk("lu_sc_b", b_sc, pc(1));

        // redirect
        ex_valid = 1; ex_redirect = 1;
        #1;
        chk("rd0_ctl_a", 32'(a_ctl), 32'(C_RD));
        chk("rd0_ctl_b", 32'(b_ctl), 32'(C_RD));
        tick();
        clr();
        #1;
        chk("rd1_ctl_a", 32'(a_ctl), 32'(C_IFF));
        chk("rd1_st_a", 32'(a_st), 32'd3);
        chk("rd1_ctl_b", 32'(b_ctl), 32'(C_NONE));
        tick();
        chk("rd2_ctl_a", 32'(a_ctl), 32'(C_NONE));
        chk("rd2_st_a", 32'(a_st), 32'd0);
        chk("rd_fe_a", a_fe, pc(1));
        chk("rd_fe_b", b_fe, pc(1));

        // busy window holding a pending redirect
        ex_valid = 1; ex_redirect = 1; dmem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("busy_ctl_a", 32'(a_ctl), 32'(C_BUSY));
            chk("busy_ctl_b", 32'(b_ctl), 32'(C_BUSY));
            tick();
        end
        dmem_busy = 0;
        #1;
        chk("busy_st_a", 32'(a_st), 32'd1);
        chk("busy_rd_a", 32'(a_ctl), 32'(C_RD));
        chk("busy_rd_b", 32'(b_ctl), 32'(C_RD));
        chk("busy_sc_a", a_sc, pc(7));
        chk("busy_sc_b", b_sc, pc(5));
        tick();
        clr();
        #1;
        chk("busy_post_st_a", 32'(a_st), 32'd3);
        tick();
        chk("busy_end_st_a", 32'(a_st), 32'd0);
        chk("busy_fe_a", a_fe, pc(2));

        // simultaneous LU and RD: redirect wins
        set_lu();
        ex_redirect = 1;
        #1;
        chk("both_ctl_a", 32'(a_ctl), 32'(C_RD));
        chk("both_ctl_b", 32'(b_ctl), 32'(C_RD));
        tick();
        ex_redirect = 0;
        #1;
        chk("both_st_a", 32'(a_st), 32'd3);
        chk("redir_ign_lu_a", 32'(a_ctl), 32'(C_IFF));
        chk("run_lu_b", 32'(b_ctl), 32'(C_LU));
        tick();
        clr();
        #1;
        chk("both_end_st_a", 32'(a_st), 32'd0);
        chk("both_fe_a", a_fe, pc(3));
        chk("both_sc_b", b_sc, pc(6));

        // x0 destination never stalls
        ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd0;
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'd0;
        #1;
        chk("x0_ctl_a", 32'(a_ctl), 32'(C_NONE));
        chk("x0_ctl_b", 32'(b_ctl), 32'(C_NONE));
        tick();
        clr();
        #1;
        chk("x0_st_a", 32'(a_st), 32'd0);

        // reset mid LU_BUBBLE with counter 2
        set_lu();
        tick();
        clr();
        #1;
        chk("pre_rst_st_a", 32'(a_st), 32'd2);
        reset = 1;
        #1;
        chk("mid_rst_ctl_a", 32'(a_ctl), 32'(C_NONE));
        chk("mid_rst_st_a", 32'(a_st), 32'd0);
        chk("mid_rst_sc_a", a_sc, 32'd0);
        tick();
        reset = 0;
        tick();
        chk("post_rst_st_a", 32'(a_st), 32'd0);
        chk("post_rst_ctl_a", 32'(a_ctl), 32'(C_NONE));
        chk("post_rst_sc_a", a_sc, 32'd0);
        chk("post_rst_fe_a", a_fe, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
